// File: rtl/and_tree_pkg.sv
// -----------------------------------------------------------------------------
// and_tree_pkg
// Shared constants and elaboration-time helpers for the pipelined AND/NAND
// reduction tree (and_tree_pipe / and_tree_stage).
//
// Contents:
//   N_MIN/N_MAX, LEVELS_MIN/LEVELS_MAX : legal parameter limits
//   tree_depth(n)         : ceil(log2(n)), 0 for n == 1
//   stage_count(n, lvls)  : max(1, ceil(tree_depth(n) / lvls))
//   level_width(w, l)     : width left after l levels of pairwise AND2
//                           reduction of a w-bit vector (odd widths padded)
//   params_legal(n, lvls) : 1 when both parameters are inside the limits
// -----------------------------------------------------------------------------
package and_tree_pkg;

  localparam int N_MIN      = 1;
  localparam int N_MAX      = 64;
  localparam int LEVELS_MIN = 1;
  localparam int LEVELS_MAX = 6;

  // ceil(log2(n)). The loop bound covers N_MAX with margin; the result
  // saturates at 7 for out-of-range widths, which params_legal rejects.
  function automatic int tree_depth(input int n);
    int d;
    d = 0;
    for (int i = 0; i < 7; i++) begin
      if ((1 << d) < n) d++;
    end
    return d;
  endfunction

  // Number of register stages. A zero-depth tree (n == 1) still gets one
  // stage so the handshake and INV always pass through a register.
  function automatic int stage_count(input int n, input int levels);
    int d;
    int s;
    d = tree_depth(n);
    if (levels < 1) return 1;
    s = (d + levels - 1) / levels;
    return (s < 1) ? 1 : s;
  endfunction

  // Each AND2 level halves the width, rounding up: an odd leftover bit is
  // passed through, which is the same as ANDing it with a constant-1 pad.
  function automatic int level_width(input int w, input int l);
    int r;
    r = w;
    for (int i = 0; i < l; i++) begin
      r = (r + 1) / 2;
    end
    return r;
  endfunction

  function automatic bit params_legal(input int n, input int levels);
    return (n >= N_MIN) && (n <= N_MAX) &&
           (levels >= LEVELS_MIN) && (levels <= LEVELS_MAX);
  endfunction

endpackage

// File: rtl/and_tree_stage.sv
// -----------------------------------------------------------------------------
// and_tree_stage
// One pipeline stage of the AND reduction tree: LEVELS levels of pairwise
// AND2 reduction followed by the stage register (valid, INV, partial product).
//
// The stage bus carries {inv, partial_product}. The last stage folds INV into
// the result with a single XOR before its register, so its output bus is the
// final 1-bit Y and no INV travels beyond it.
//
// Parameters:
//   W      : width of the incoming partial-product vector
//   LEVELS : AND2 levels in this stage (0 allowed for a 1-input tree)
//   LAST   : 1 for the final stage (XOR with INV, 1-bit output)
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : upstream stage (or producer) holds a transaction
//   in_bus     : {inv, partial[W-1:0]} from upstream
//   adv        : downstream takes this stage's transaction this cycle
//   valid_q    : this stage holds a transaction
//   out_bus    : registered {inv, partial} (or {y} when LAST)
// -----------------------------------------------------------------------------
module and_tree_stage
  import and_tree_pkg::*;
#(
  parameter int W      = 8,
  parameter int LEVELS = 1,
  parameter bit LAST   = 1'b0,
  localparam int WO    = level_width(W, LEVELS),
  localparam int OW    = LAST ? 1 : WO + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W:0]    in_bus,
  input  logic          adv,
  output logic          valid_q,
  output logic [OW-1:0] out_bus
);

  logic [W-1:0]  data_in;
  logic          inv_in;
  logic [WO-1:0] red;
  logic [OW-1:0] nxt;
  logic          en;

  assign {inv_in, data_in} = in_bus;

  // Reduction levels. Each level gets its own exactly-sized vector so no
  // partially used bits are left behind.
  if (LEVELS == 0) begin : g_pass
    assign red = data_in;
  end else begin : g_tree
    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int WI = level_width(W, l);
      localparam int WN = level_width(W, l + 1);
      logic [WI-1:0] d;
      logic [WN-1:0] q;

      if (l == 0) begin : g_src
        assign d = data_in;
      end else begin : g_src
        assign d = g_lvl[l-1].q;
      end

      for (genvar i = 0; i < WN; i++) begin : g_pair
        if (2 * i + 1 < WI) begin : g_and
          assign q[i] = d[2*i] & d[2*i+1];
        end else begin : g_pad
          // Odd width: partner is the constant-1 pad, so the bit passes.
          assign q[i] = d[2*i];
        end
      end
    end
    assign red = g_lvl[LEVELS-1].q;
  end

  if (LAST) begin : g_last
    assign nxt = red[0] ^ inv_in;
  end else begin : g_mid
    assign nxt = {inv_in, red};
  end

  // Capture when empty or when the current occupant is moving on.
  assign en = !valid_q || adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_bus <= '0;
    end else if (en) begin
      valid_q <= in_valid;
      // Bubbles do not overwrite the data register.
      if (in_valid) out_bus <= nxt;
    end
  end

endmodule

// File: rtl/and_tree_pipe.sv
// -----------------------------------------------------------------------------
// and_tree_pipe
// Pipelined N-input AND/NAND reduction with valid/ready at both ends.
// Y = (&A) ^ INV of each accepted transaction, delivered in acceptance order
// after S = max(1, ceil(ceil(log2 N) / LEVELS)) register stages.
//
// Parameters:
//   N      : operand width, 1..64
//   LEVELS : AND2 levels per register stage, 1..6
//
// Ports:
//   CLK       : rising-edge clock
//   R         : asynchronous active-low reset
//   IN_VALID  : producer has A/INV
//   IN_READY  : block accepts A/INV this cycle
//   A         : operand vector
//   INV       : 0 = AND, 1 = NAND (per transaction)
//   OUT_VALID : Y holds a result
//   OUT_READY : consumer takes Y this cycle
//   Y         : reduction result
//   BUSY      : at least one stage holds a transaction
//
// Handshake: a transfer happens at a rising CLK edge where VALID && READY on
// that side. The producer holds IN_VALID/A/INV stable until accepted; Y is
// held stable while OUT_VALID && !OUT_READY. IN_READY depends on OUT_READY
// and the stage valid bits only, never on IN_VALID.
// -----------------------------------------------------------------------------
module and_tree_pipe
  import and_tree_pkg::*;
#(
  parameter int N      = 8,
  parameter int LEVELS = 1
) (
  input  logic         CLK,
  input  logic         R,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic         INV,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic         Y,
  output logic         BUSY
);

  localparam int D = tree_depth(N);
  localparam int S = stage_count(N, LEVELS);

  if (!params_legal(N, LEVELS)) begin : g_param_check
    $error("and_tree_pipe: N=%0d or LEVELS=%0d outside legal range", N, LEVELS);
  end

  logic [S-1:0] valid;
  logic [S-1:0] adv;

  // adv[k] = !valid[k+1] || adv[k+1], unrolled: stage k advances when the
  // consumer is ready or any stage downstream of k is empty (that bubble
  // absorbs the shift). Written in closed form to avoid a self-referencing
  // vector in the combinational chain.
  always_comb begin
    adv = '0;
    for (int k = 0; k < S; k++) begin
      adv[k] = OUT_READY;
      for (int j = k + 1; j < S; j++) begin
        if (!valid[j]) adv[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam bit LAST = (k == S - 1);
    localparam int WK   = level_width(N, k * LEVELS);
    localparam int LK   = LAST ? (D - k * LEVELS) : LEVELS;
    localparam int OW   = LAST ? 1 : level_width(N, (k + 1) * LEVELS) + 1;

    logic          stage_in_valid;
    logic [WK:0]   in_bus;
    logic [OW-1:0] out_bus;

    if (k == 0) begin : g_head
      assign stage_in_valid = IN_VALID;
      assign in_bus         = {INV, A};
    end else begin : g_link
      assign stage_in_valid = valid[k-1];
      assign in_bus         = g_stage[k-1].out_bus;
    end

    and_tree_stage #(
      .W      (WK),
      .LEVELS (LK),
      .LAST   (LAST)
    ) u_stage (
      .clk      (CLK),
      .rst_n    (R),
      .in_valid (stage_in_valid),
      .in_bus   (in_bus),
      .adv      (adv[k]),
      .valid_q  (valid[k]),
      .out_bus  (out_bus)
    );
  end

  assign IN_READY  = !valid[0] || adv[0];
  assign OUT_VALID = valid[S-1];
  assign Y         = g_stage[S-1].out_bus[0];
  assign BUSY      = |valid;

endmodule

// File: tb/tb_and_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_and_tree_pipe
// Four instances: d0 N=8/L=1 (S=3), d1 N=5/L=1 (S=3), d2 N=1 (S=1),
// d3 N=64/L=2 (S=3). A reference model (expected-result queue tagged by
// instance, plus in-flight count) is compared against every instance on every
// falling edge; directed sections pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_and_tree_pipe;

  typedef struct {
    int   d;
    int   cyc;
    logic y;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [3:0]  inv_r;
  logic [3:0]  out_ready;
  logic [63:0] a_bus [4];
  wire  [3:0]  in_ready;
  wire  [3:0]  out_valid;
  wire  [3:0]  y;
  wire  [3:0]  busy;

  int n_tab [4] = '{8, 5, 1, 64};
  int s_tab [4] = '{3, 3, 1, 3};

  // Scoreboard: entries are {instance[1:0], expected_y}.
  logic [2:0] exp_q[$];
  ev_t        out_log[$];
  ev_t        acc_log[$];
  logic [3:0] prev_hold;
  logic [3:0] prev_y;
  int         cyc;
  int         tests;
  int         fails;
  bit         rand_done;

  logic [63:0] st_a [4] = '{64'hFF, 64'h00, 64'h7F, 64'hFF};
  logic        st_i [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  and_tree_pipe #(.N(8), .LEVELS(1)) u_dut0 (
    .CLK(clk), .R(rst_n), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
    .A(a_bus[0][7:0]), .INV(inv_r[0]), .OUT_VALID(out_valid[0]),
    .OUT_READY(out_ready[0]), .Y(y[0]), .BUSY(busy[0]));

  and_tree_pipe #(.N(5), .LEVELS(1)) u_dut1 (
    .CLK(clk), .R(rst_n), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
    .A(a_bus[1][4:0]), .INV(inv_r[1]), .OUT_VALID(out_valid[1]),
    .OUT_READY(out_ready[1]), .Y(y[1]), .BUSY(busy[1]));

  and_tree_pipe #(.N(1), .LEVELS(1)) u_dut2 (
    .CLK(clk), .R(rst_n), .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]),
    .A(a_bus[2][0:0]), .INV(inv_r[2]), .OUT_VALID(out_valid[2]),
    .OUT_READY(out_ready[2]), .Y(y[2]), .BUSY(busy[2]));

  and_tree_pipe #(.N(64), .LEVELS(2)) u_dut3 (
    .CLK(clk), .R(rst_n), .IN_VALID(in_valid[3]), .IN_READY(in_ready[3]),
    .A(a_bus[3]), .INV(inv_r[3]), .OUT_VALID(out_valid[3]),
    .OUT_READY(out_ready[3]), .Y(y[3]), .BUSY(busy[3]));

  // ---------------- helpers ----------------
  task automatic chk_bit(string name, int d, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0b required %0b (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  task automatic chk_int(string name, int d, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d required %0d", name, d, act, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic int sb_count(int d);
    int n;
    n = 0;
    foreach (exp_q[i]) if (int'(exp_q[i][2:1]) == d) n++;
    return n;
  endfunction

  function automatic int sb_find(int d);
    foreach (exp_q[i]) if (int'(exp_q[i][2:1]) == d) return i;
    return -1;
  endfunction

  function automatic int log_count(bit outs, int d);
    int n;
    n = 0;
    if (outs) begin
      foreach (out_log[i]) if (out_log[i].d == d) n++;
    end else begin
      foreach (acc_log[i]) if (acc_log[i].d == d) n++;
    end
    return n;
  endfunction

  function automatic ev_t log_get(bit outs, int d, int k);
    ev_t e;
    int  n;
    e = '{-1, -1, 1'bx};
    n = 0;
    if (outs) begin
      foreach (out_log[i]) if (out_log[i].d == d) begin
        if (n == k) e = out_log[i];
        n++;
      end
    end else begin
      foreach (acc_log[i]) if (acc_log[i].d == d) begin
        if (n == k) e = acc_log[i];
        n++;
      end
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one vector and holds it until the accepting edge has passed.
  task automatic send(int d, logic [63:0] a, logic i);
    logic rdy;
    in_valid[d] = 1'b1;
    a_bus[d]    = a;
    inv_r[d]    = i;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      rdy = in_ready[d];
      @(posedge clk);
      #1;
      if (rdy) return;
    end
    tests++;
    fails++;
    $display("FAIL send_timeout dut%0d: no accept within 200 cycles, required accept", d);
  endtask

  task automatic clear_logs();
    out_log.delete();
    acc_log.delete();
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 4; d++) begin
      if (!rst_n) begin
        chk_bit("rst_out_valid", d, out_valid[d], 1'b0);
        chk_bit("rst_y", d, y[d], 1'b0);
        chk_bit("rst_busy", d, busy[d], 1'b0);
        chk_bit("rst_in_ready", d, in_ready[d], 1'b1);
        prev_hold[d] = 1'b0;
      end else begin
        int n;
        int idx;
        n = sb_count(d);
        // Full means S in flight; only a ready consumer frees a slot then.
        chk_bit("in_ready", d, in_ready[d], (n < s_tab[d]) || out_ready[d]);
        chk_bit("busy", d, busy[d], n != 0);
        if (prev_hold[d]) begin
          chk_bit("hold_valid", d, out_valid[d], 1'b1);
          chk_bit("hold_y", d, y[d], prev_y[d]);
        end
        if (n == 0) begin
          chk_bit("spurious_valid", d, out_valid[d], 1'b0);
        end else if (out_valid[d]) begin
          idx = sb_find(d);
          chk_bit("y", d, y[d], exp_q[idx][0]);
          if (out_ready[d]) begin
            out_log.push_back('{d, cyc, y[d]});
            exp_q.delete(idx);
          end
        end
        prev_hold[d] = out_valid[d] && !out_ready[d];
        prev_y[d]    = y[d];
        if (in_valid[d] && in_ready[d]) begin
          exp_q.push_back({2'(d),
            ((a_bus[d] & mask_of(n_tab[d])) == mask_of(n_tab[d])) ^ inv_r[d]});
          acc_log.push_back('{d, cyc, 1'b0});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ev_t e0;
    ev_t e1;
    int  k;
    logic rdy;

    tests     = 0;
    fails     = 0;
    cyc       = 0;
    rand_done = 1'b0;
    prev_hold = '0;
    prev_y    = '0;
    rst_n     = 1'b0;
    in_valid  = '0;
    inv_r     = '0;
    out_ready = '1;
    for (int d = 0; d < 4; d++) a_bus[d] = '0;

    #23 rst_n = 1'b1;
    tick(1);

    // Basic results: FF/0 -> 1, FE/0 -> 0, FF/1 -> 0, first result 3 cycles on.
    clear_logs();
    send(0, 64'hFF, 1'b0);
    send(0, 64'hFE, 1'b0);
    send(0, 64'hFF, 1'b1);
    in_valid[0] = 1'b0;
    tick(6);
    chk_int("basic_count", 0, log_count(1, 0), 3);
    e0 = log_get(1, 0, 0);
    chk_bit("basic_y0", 0, e0.y, 1'b1);
    chk_bit("basic_y1", 0, log_get(1, 0, 1).y, 1'b0);
    chk_bit("basic_y2", 0, log_get(1, 0, 2).y, 1'b0);
    chk_int("basic_latency", 0, e0.cyc - log_get(0, 0, 0).cyc, 3);
    chk_int("basic_back2back", 0, log_get(1, 0, 2).cyc - e0.cyc, 2);

    // Stall and resume: three accepts fill the pipe, then IN_READY drops.
    clear_logs();
    out_ready[0] = 1'b0;
    k = 0;
    in_valid[0] = 1'b1;
    a_bus[0]    = st_a[0];
    inv_r[0]    = st_i[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rdy = in_ready[0];
      @(posedge clk);
      #1;
      if (rdy) begin
        k++;
        if (k < 4) begin
          a_bus[0] = st_a[k];
          inv_r[0] = st_i[k];
        end
      end
    end
    chk_int("stall_accepts", 0, log_count(0, 0), 3);
    @(negedge clk);
    chk_bit("stall_in_ready", 0, in_ready[0], 1'b0);
    chk_bit("stall_out_valid", 0, out_valid[0], 1'b1);
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk_bit("resume_in_ready", 0, in_ready[0], 1'b1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    tick(6);
    chk_int("resume_outs", 0, log_count(1, 0), 4);
    chk_bit("resume_y0", 0, log_get(1, 0, 0).y, 1'b1);
    chk_bit("resume_y1", 0, log_get(1, 0, 1).y, 1'b1);
    chk_bit("resume_y2", 0, log_get(1, 0, 2).y, 1'b0);
    chk_bit("resume_y3", 0, log_get(1, 0, 3).y, 1'b0);
    chk_int("resume_same_edge", 0, log_get(0, 0, 3).cyc, log_get(1, 0, 0).cyc);

    // Padding (N=5) and single input (N=1).
    clear_logs();
    send(1, 64'h1F, 1'b0);
    send(1, 64'h0F, 1'b0);
    send(1, 64'h1F, 1'b1);
    send(1, 64'h00, 1'b1);
    in_valid[1] = 1'b0;
    send(2, 64'h1, 1'b0);
    send(2, 64'h0, 1'b0);
    send(2, 64'h0, 1'b1);
    in_valid[2] = 1'b0;
    tick(6);
    chk_bit("pad5_1f", 1, log_get(1, 1, 0).y, 1'b1);
    chk_bit("pad5_0f", 1, log_get(1, 1, 1).y, 1'b0);
    chk_bit("pad5_1f_nand", 1, log_get(1, 1, 2).y, 1'b0);
    chk_bit("pad5_00_nand", 1, log_get(1, 1, 3).y, 1'b1);
    chk_bit("n1_one", 2, log_get(1, 2, 0).y, 1'b1);
    chk_bit("n1_zero", 2, log_get(1, 2, 1).y, 1'b0);
    chk_bit("n1_zero_nand", 2, log_get(1, 2, 2).y, 1'b1);
    chk_int("n1_latency", 2, log_get(1, 2, 0).cyc - log_get(0, 2, 0).cyc, 1);

    // Reset mid-operation with two transactions held in the pipe.
    out_ready[0] = 1'b0;
    send(0, 64'hFF, 1'b0);
    send(0, 64'h00, 1'b0);
    in_valid[0] = 1'b0;
    tick(2);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_bit("midrst_out_valid", 0, out_valid[0], 1'b0);
    chk_bit("midrst_busy", 0, busy[0], 1'b0);
    chk_bit("midrst_y", 0, y[0], 1'b0);
    chk_bit("midrst_in_ready", 0, in_ready[0], 1'b1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick(1);
    out_ready[0] = 1'b1;
    clear_logs();
    tick(5);
    chk_int("postrst_no_stale", 0, log_count(1, 0), 0);
    send(0, 64'h00, 1'b1);
    in_valid[0] = 1'b0;
    tick(6);
    chk_int("postrst_count", 0, log_count(1, 0), 1);
    e1 = log_get(1, 0, 0);
    chk_bit("postrst_y", 0, e1.y, 1'b1);
    chk_int("postrst_latency", 0, e1.cyc - log_get(0, 0, 0).cyc, 3);

    // Random backpressure on N=64, LEVELS=2.
    fork
      begin
        logic [63:0] a;
        for (int v = 0; v < 10000; v++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid[3] = 1'b0;
            tick(1);
          end
          case ($urandom_range(0, 3))
            0:       a = '1;
            1: begin
              a = '1;
              a[$urandom_range(0, 63)] = 1'b0;
            end
            default: a = {$urandom, $urandom};
          endcase
          send(3, a, 1'($urandom_range(0, 1)));
        end
        in_valid[3] = 1'b0;
        rand_done   = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready[3] = ($urandom_range(0, 99) < 65);
        end
      end
    join
    out_ready[3] = 1'b1;
    for (int t = 0; t < 50 && sb_count(3) != 0; t++) tick(1);
    chk_int("random_drained", 3, sb_count(3), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
